branch_outcome_queue: RTL and testbench
=======================================

BRANCH_OUTCOME_QUEUE -- requirements
Module: branch_outcome_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of in-flight branch entries (power of two, at least 2).
REQ-002 SHALL have parameter PC_W, default 32, width of the branch PC.
REQ-003 SHALL have port CLK  input  1  single clock for all state, rising edge.
REQ-004 SHALL have port RES  input  1  synchronous active-high reset.
REQ-005 SHALL have port push_valid  input  1  fetch presents a predicted branch.
REQ-006 SHALL have port push_ready  output  1  queue accepts the push this cycle.
REQ-007 SHALL have port push_pc  input  PC_W  PC of the pushed branch.
REQ-008 SHALL have port push_pred  input  1  predictor direction for the pushed branch.
REQ-009 SHALL have port res_valid  input  1  oldest branch resolved this cycle, in program order.
REQ-010 SHALL have port res_taken  input  1  actual direction of the resolved branch.
REQ-011 SHALL have port train_en  output  1  one-cycle pulse; drives predictor train_en and history_update_en.
REQ-012 SHALL have port train_pc  output  PC_W  PC of the trained entry.
REQ-013 SHALL have port train_taken  output  1  actual direction; drives predictor actual_taken and branch_taken.
REQ-014 SHALL have port mispredict  output  1  one-cycle pulse when stored prediction differs from res_taken.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-016 SHALL have port underflow_err  output  1  sticky flag, set by res_valid while empty.

Function
REQ-017 SHALL assert push_ready = (occupancy < DEPTH) && (state == RUN); there is no same-cycle bypass from a pop.
REQ-018 SHALL write {push_pc, push_pred} at the tail when push_valid && push_ready; the tail pointer wraps modulo DEPTH.
REQ-019 SHALL, on res_valid with occupancy > 0, pop the head and register train_en=1, train_pc=head pc, train_taken=res_taken on the next edge, giving a latency of 1 cycle.
REQ-020 SHALL register mispredict=1 in the same cycle as train_en when head pred != res_taken, and 0 otherwise.
REQ-021 SHALL, on a mispredicting pop, discard all remaining entries including any push accepted in the same cycle, so that occupancy reads 0 on the next cycle.
REQ-022 SHALL implement FSM states RUN and FLUSH: RUN->FLUSH on a mispredicting pop; FLUSH->RUN after exactly 1 cycle; push_ready=0 during FLUSH; res_valid during FLUSH is treated as underflow.
REQ-023 SHALL allow a simultaneous non-mispredicting push and pop, leaving occupancy unchanged.
REQ-024 SHALL ignore res_valid with occupancy 0: no pop, train_en=0, underflow_err set until reset.
REQ-025 SHALL hold train_pc and train_taken at their last values when train_en=0.

Reset
REQ-026 SHALL, on RES sampled high, clear pointers, occupancy=0, state=RUN, train_en=0, train_pc=0, train_taken=0, mispredict=0, underflow_err=0 and all counters=0; storage contents are don't-care.
REQ-027 SHALL give RES priority over all same-cycle push and resolve activity; entries in flight are lost.

Configuration
REQ-028 SHALL, when BOQ_STATS_EN is defined, add outputs branch_count[31:0] and mispred_count[31:0], incremented per pop and per mispredicting pop and saturating at 0xFFFFFFFF.
REQ-029 SHALL, when BOQ_STATS_EN is undefined, contain neither those ports nor the counter logic.

Structure
REQ-030 SHALL take boq_entry_t {pc, pred} and BOQ_DEPTH_DEFAULT from shared package ronanchip_pkg.
REQ-031 SHALL implement storage, pointers and FSM inline, with no sub-module.

Verification
REQ-032 SHALL cover this scenario: reset, then push 8 entries -> push_ready=0 at occupancy 8; a 9th push is not accepted.
REQ-033 SHALL cover this scenario: push pc 0x100 with pred=1, then res_valid with res_taken=1 -> next cycle train_en=1, train_pc=0x100, mispredict=0, occupancy 0.
REQ-034 SHALL cover this scenario: push 3 entries (pred=0), resolve the first with taken=1 -> mispredict=1, occupancy 0, push_ready=0 for 1 cycle, then 1.
REQ-035 SHALL cover this scenario: with occupancy 4, push and non-mispredicting resolve in the same cycle -> occupancy stays 4, FIFO order preserved across pointer wrap over 20 operations.
REQ-036 SHALL cover this scenario: res_valid while empty -> train_en=0, underflow_err=1 until RES.
REQ-037 SHALL cover this scenario: with BOQ_STATS_EN defined, 10 resolves including 3 mispredictions -> branch_count=10, mispred_count=3; RES asserted mid-stream clears both and occupancy.

Source files
------------

// File: rtl/ronanchip_pkg.sv
// rtl/ronanchip_pkg.sv - shared types and defaults for the branch outcome queue
package ronanchip_pkg;

  localparam int BOQ_DEPTH_DEFAULT = 8;
  // Entry PC field is sized for the widest supported PC; narrower PCs are zero-extended.
  localparam int BOQ_PC_MAX_W = 64;

  typedef struct packed {
    logic [BOQ_PC_MAX_W-1:0] pc;
    logic                    pred;
  } boq_entry_t;

  typedef enum logic {
    BOQ_RUN   = 1'b0,
    BOQ_FLUSH = 1'b1
  } boq_state_e;

endpackage

// File: rtl/branch_outcome_queue.sv
// rtl/branch_outcome_queue.sv - in-order queue of predicted branches driving predictor training
// Define BOQ_STATS_EN to add the branch_count / mispred_count event counters.
module branch_outcome_queue
  import ronanchip_pkg::*;
#(
  parameter int DEPTH = BOQ_DEPTH_DEFAULT,
  parameter int PC_W  = 32
) (
  input  logic                   CLK,
  input  logic                   RES,
  input  logic                   push_valid,
  output logic                   push_ready,
  input  logic [PC_W-1:0]        push_pc,
  input  logic                   push_pred,
  input  logic                   res_valid,
  input  logic                   res_taken,
  output logic                   train_en,
  output logic [PC_W-1:0]        train_pc,
  output logic                   train_taken,
  output logic                   mispredict,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   underflow_err
`ifdef BOQ_STATS_EN
  ,
  output logic [31:0]            branch_count,
  output logic [31:0]            mispred_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  boq_entry_t       r_mem [DEPTH];
  logic [AW-1:0]    r_head;
  logic [AW-1:0]    r_tail;
  logic [AW:0]      r_count;
  boq_state_e       r_state;
  logic             r_train_en;
  logic [PC_W-1:0]  r_train_pc;
  logic             r_train_taken;
  logic             r_mispredict;
  logic             r_underflow;

  boq_entry_t       w_head;
  logic             w_push_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_mis;
  logic             w_underflow;

  assign w_head       = r_mem[r_head];
  assign w_push_ready = (r_count < FULL_COUNT) && (r_state == BOQ_RUN);
  assign w_push       = push_valid && w_push_ready;
  // The queue is always empty during FLUSH, so any resolve there is an underflow.
  assign w_pop        = res_valid && (r_count != '0) && (r_state == BOQ_RUN);
  assign w_mis        = w_pop && (w_head.pred != res_taken);
  assign w_underflow  = res_valid && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_tail] <= '{pc: BOQ_PC_MAX_W'(push_pc), pred: push_pred};
    end
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_state       <= BOQ_RUN;
      r_train_en    <= 1'b0;
      r_train_pc    <= '0;
      r_train_taken <= 1'b0;
      r_mispredict  <= 1'b0;
      r_underflow   <= 1'b0;
    end else begin
      r_train_en   <= w_pop;
      r_mispredict <= w_mis;
      if (w_pop) begin
        r_train_pc    <= PC_W'(w_head.pc);
        r_train_taken <= res_taken;
      end
      if (w_underflow) begin
        r_underflow <= 1'b1;
      end
      // A mispredict squashes every younger entry, including a push landing this cycle.
      if (w_mis) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_state <= BOQ_FLUSH;
      end else begin
        r_state <= BOQ_RUN;
        if (w_push) begin
          r_tail <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_head <= r_head + 1'b1;
        end
        r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
    end
  end

`ifdef BOQ_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_mispred_count;

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_branch_count  <= '0;
      r_mispred_count <= '0;
    end else begin
      if (w_pop && (r_branch_count != '1)) begin
        r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mis && (r_mispred_count != '1)) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

  assign branch_count  = r_branch_count;
  assign mispred_count = r_mispred_count;
`endif

  assign push_ready    = w_push_ready;
  assign train_en      = r_train_en;
  assign train_pc      = r_train_pc;
  assign train_taken   = r_train_taken;
  assign mispredict    = r_mispredict;
  assign occupancy     = r_count;
  assign underflow_err = r_underflow;

endmodule

// File: tb/tb_branch_outcome_queue.sv
// tb/tb_branch_outcome_queue.sv - self-checking bench for branch_outcome_queue
// Counter checks are included when BOQ_STATS_EN is defined.
module tb_branch_outcome_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic                   CLK = 1'b0;
  logic                   RES;
  logic                   push_valid;
  logic                   push_ready;
  logic [PC_W-1:0]        push_pc;
  logic                   push_pred;
  logic                   res_valid;
  logic                   res_taken;
  logic                   train_en;
  logic [PC_W-1:0]        train_pc;
  logic                   train_taken;
  logic                   mispredict;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   underflow_err;
`ifdef BOQ_STATS_EN
  logic [31:0]            branch_count;
  logic [31:0]            mispred_count;
`endif

  always #5 CLK = ~CLK;

  branch_outcome_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .CLK           (CLK),
    .RES           (RES),
    .push_valid    (push_valid),
    .push_ready    (push_ready),
    .push_pc       (push_pc),
    .push_pred     (push_pred),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .train_en      (train_en),
    .train_pc      (train_pc),
    .train_taken   (train_taken),
    .mispredict    (mispredict),
    .occupancy     (occupancy),
    .underflow_err (underflow_err)
`ifdef BOQ_STATS_EN
    ,
    .branch_count  (branch_count),
    .mispred_count (mispred_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of outstanding branches plus the flush bubble flag.
  typedef struct {
    logic [PC_W-1:0] pc;
    logic            pred;
  } ment_t;

  ment_t           mq[$];
  logic            m_flush = 1'b0;
  logic            m_uf = 1'b0;
  logic            m_te = 1'b0;
  logic            m_mis = 1'b0;
  logic            m_taken = 1'b0;
  logic [PC_W-1:0] m_pc = '0;
  longint          m_bc = 0;
  longint          m_mc = 0;

  task automatic step(input logic rst, input logic pv, input logic [PC_W-1:0] pc,
                      input logic pred, input logic rv, input logic rt);
    bit    acc;
    bit    pop;
    ment_t e;
    RES        = rst;
    push_valid = pv;
    push_pc    = pc;
    push_pred  = pred;
    res_valid  = rv;
    res_taken  = rt;
    acc = pv && (mq.size() < DEPTH) && !m_flush;
    pop = rv && (mq.size() > 0) && !m_flush;
    @(posedge CLK);
    #1;
    if (rst) begin
      mq.delete();
      m_flush = 1'b0; m_uf = 1'b0; m_te = 1'b0; m_mis = 1'b0;
      m_pc = '0; m_taken = 1'b0; m_bc = 0; m_mc = 0;
    end else begin
      m_te  = pop;
      m_mis = 1'b0;
      if (pop) begin
        e       = mq.pop_front();
        m_pc    = e.pc;
        m_taken = rt;
        m_mis   = (e.pred != rt);
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (m_mis && m_mc < 64'hFFFF_FFFF) m_mc++;
      end
      if (rv && !pop) m_uf = 1'b1;
      if (m_mis) begin
        mq.delete();
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (acc) mq.push_back('{pc, pred});
      end
    end
    chk("model_train_en", train_en, m_te);
    chk("model_mispredict", mispredict, m_mis);
    chk("model_train_pc", train_pc, m_pc);
    chk("model_train_taken", train_taken, m_taken);
    chk("model_occupancy", occupancy, mq.size());
    chk("model_push_ready", push_ready, (mq.size() < DEPTH) && !m_flush);
    chk("model_underflow", underflow_err, m_uf);
`ifdef BOQ_STATS_EN
    chk("model_branch_count", branch_count, m_bc);
    chk("model_mispred_count", mispred_count, m_mc);
`endif
    RES = 1'b0; push_valid = 1'b0; res_valid = 1'b0;
  endtask

  typedef struct {
    logic        pv;
    logic [31:0] pc;
    logic        pred;
    logic        rv;
    logic        rt;
    logic        e_te;
    logic [31:0] e_pc;
    logic        e_tk;
    logic        e_mis;
    int          e_occ;
    logic        e_rdy;
    logic        e_uf;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    RES = 1'b1; push_valid = 1'b0; push_pc = '0; push_pred = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;

    //            pv pc          pr rv rt  te e_pc        tk mis occ rdy uf
    vecs.push_back('{1, 32'h100, 1, 0, 0,  0, 32'h000,    0, 0,  1,  1,  0});
    vecs.push_back('{0, 32'h0,   0, 1, 1,  1, 32'h100,    1, 0,  0,  1,  0});
    vecs.push_back('{1, 32'h200, 0, 0, 0,  0, 32'h100,    1, 0,  1,  1,  0});
    vecs.push_back('{1, 32'h204, 0, 0, 0,  0, 32'h100,    1, 0,  2,  1,  0});
    vecs.push_back('{1, 32'h208, 0, 0, 0,  0, 32'h100,    1, 0,  3,  1,  0});
    vecs.push_back('{0, 32'h0,   0, 1, 1,  1, 32'h200,    1, 1,  0,  0,  0});
    vecs.push_back('{0, 32'h0,   0, 0, 0,  0, 32'h200,    1, 0,  0,  1,  0});
    vecs.push_back('{1, 32'h300, 1, 0, 0,  0, 32'h200,    1, 0,  1,  1,  0});
    vecs.push_back('{1, 32'h304, 0, 1, 1,  1, 32'h300,    1, 0,  1,  1,  0});
    vecs.push_back('{1, 32'h308, 1, 1, 0,  1, 32'h304,    0, 0,  1,  1,  0});
    vecs.push_back('{1, 32'h30C, 0, 1, 0,  1, 32'h308,    0, 1,  0,  0,  0});
    vecs.push_back('{1, 32'h400, 1, 1, 1,  0, 32'h308,    0, 0,  0,  1,  1});
    vecs.push_back('{0, 32'h0,   0, 0, 0,  0, 32'h308,    0, 0,  0,  1,  1});
    vecs.push_back('{1, 32'h500, 0, 0, 0,  0, 32'h308,    0, 0,  1,  1,  1});

    // Reset state
    step(1, 0, '0, 0, 0, 0);
    step(1, 0, '0, 0, 0, 0);
    chk("reset_occupancy", occupancy, 0);
    chk("reset_push_ready", push_ready, 1);
    chk("reset_train_pc", train_pc, 0);
    chk("reset_underflow", underflow_err, 0);

    foreach (vecs[i]) begin
      step(0, vecs[i].pv, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].rt);
      chk($sformatf("vec%0d_train_en", i), train_en, vecs[i].e_te);
      chk($sformatf("vec%0d_train_pc", i), train_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d_train_taken", i), train_taken, vecs[i].e_tk);
      chk($sformatf("vec%0d_mispredict", i), mispredict, vecs[i].e_mis);
      chk($sformatf("vec%0d_occupancy", i), occupancy, vecs[i].e_occ);
      chk($sformatf("vec%0d_push_ready", i), push_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_underflow", i), underflow_err, vecs[i].e_uf);
    end

    // Full queue: ready drops at DEPTH, ninth push refused, then reset wins over activity
    step(1, 0, '0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 32'h800 + 32'(i * 4), 1, 0, 0);
      chk("full_push_ready", push_ready, (i < DEPTH - 1));
    end
    step(0, 1, 32'hDEAD, 1, 0, 0);
    chk("full_ninth_occupancy", occupancy, DEPTH);
    step(1, 1, 32'hBEEF, 1, 1, 1);
    chk("reset_prio_occupancy", occupancy, 0);
    chk("reset_prio_train_en", train_en, 0);

    // Steady push+resolve at occupancy 4 across pointer wrap
    for (int i = 0; i < 4; i++) step(0, 1, 32'h1000 + 32'(i * 4), 1, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 32'h1000 + 32'((i + 4) * 4), 1, 1, 1);
      chk("wrap_train_pc", train_pc, 32'h1000 + 32'(i * 4));
      chk("wrap_occupancy", occupancy, 4);
      chk("wrap_mispredict", mispredict, 0);
    end

    // Resolve while empty: sticky underflow until reset
    step(1, 0, '0, 0, 0, 0);
    step(0, 0, '0, 0, 1, 1);
    chk("empty_res_train_en", train_en, 0);
    chk("empty_res_underflow", underflow_err, 1);
    step(0, 1, 32'h44, 0, 0, 0);
    step(0, 0, '0, 0, 1, 0);
    chk("underflow_sticky", underflow_err, 1);
    step(1, 0, '0, 0, 0, 0);
    chk("underflow_cleared", underflow_err, 0);

`ifdef BOQ_STATS_EN
    for (int i = 0; i < 10; i++) begin
      logic mis;
      mis = (i == 2) || (i == 5) || (i == 8);
      step(0, 1, 32'h2000 + 32'(i * 4), 1, 0, 0);
      step(0, 0, '0, 0, 1, !mis);
      step(0, 0, '0, 0, 0, 0);
    end
    chk("stats_branch_count", branch_count, 10);
    chk("stats_mispred_count", mispred_count, 3);
    step(0, 1, 32'h3000, 0, 0, 0);
    step(0, 1, 32'h3004, 0, 0, 0);
    step(1, 1, 32'h3008, 0, 1, 0);
    chk("stats_reset_branch", branch_count, 0);
    chk("stats_reset_mispred", mispred_count, 0);
    chk("stats_reset_occupancy", occupancy, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic rst, pv, pred, rv, rt;
      rst  = ($urandom_range(0, 199) == 0);
      pv   = ($urandom_range(0, 9) < 7);
      pred = $urandom_range(0, 1) != 0;
      rv   = ($urandom_range(0, 1) != 0);
      if (mq.size() > 0) rt = ($urandom_range(0, 7) == 0) ? !mq[0].pred : mq[0].pred;
      else rt = $urandom_range(0, 1) != 0;
      step(rst, pv, $urandom(), pred, rv, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
